// File: rtl/blob_counter_cc.sv
// rtl/blob_counter_cc.sv - streaming connected-component blob counter for binary masks
//
// One raster pass labels each foreground pixel from its causal neighbours (W, NW, N, NE
// or W, N), merges label equivalences in a union-find table and accumulates the area of
// every label. After the last pixel the table is flattened and the roots whose area
// reaches the sampled minimum are counted.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid / o_ready     pixel handshake; a pixel transfers when both are high
//   i_sof                 marks the first pixel of a frame (restarts a frame in progress)
//   i_pixel               1 = foreground
//   i_min_area            minimum blob area, sampled with the i_sof pixel
//   o_done                one-cycle pulse when o_count / o_overflow are updated
//   o_count               blob count of the last completed frame
//   o_overflow            label table ran out during the last completed frame

module blob_counter_cc #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int NUM_LABELS = 256,
    parameter int AREA_W     = 19,
    parameter int CNT_W      = 8,
    parameter int CONNECT    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic              i_pixel,
    input  logic [AREA_W-1:0] i_min_area,
    output logic              o_ready,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow
);

    localparam int LW  = $clog2(NUM_LABELS);
    localparam int NLW = LW + 1;
    localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [NLW-1:0] NL_FULL  = NLW'(NUM_LABELS);
    localparam logic [XW-1:0]  COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]  ROW_LAST = YW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LABEL,
        S_MERGE,
        S_FLATTEN,
        S_COUNT,
        S_DONE
    } state_t;

    state_t             state;
    logic [YW-1:0]      row;
    logic [XW-1:0]      col;
    logic [NLW-1:0]     next_label;
    logic [LW-1:0]      w_lab;
    logic [LW-1:0]      nw_lab;
    logic [LW-1:0]      ra;
    logic [LW-1:0]      rb;
    logic               merge_last;
    logic               frame_ovf;
    logic [NLW-1:0]     idx;
    logic [CNT_W-1:0]   cnt;
    logic [AREA_W-1:0]  min_area_q;

    // Tables are never cleared: a label is (re)initialised when it is allocated.
    logic [LW-1:0]      lb   [IMG_W];
    logic [LW-1:0]      par  [NUM_LABELS];
    logic [AREA_W-1:0]  area [NUM_LABELS];

    logic               take;
    logic [YW-1:0]      eff_row;
    logic [XW-1:0]      eff_col;
    logic [XW-1:0]      ne_col;
    logic [NLW-1:0]     eff_nl;
    logic               has_n;
    logic               has_w;
    logic               has_e;
    logic [LW-1:0]      n_raw;
    logic [LW-1:0]      nb [4];
    logic [LW-1:0]      lo;
    logic [LW-1:0]      hi;
    logic               any_nb;
    logic [LW-1:0]      pa;
    logic [LW-1:0]      pb;
    logic [LW-1:0]      lab;
    logic               alloc;
    logic               inc;
    logic               ovf_px;
    logic               need_merge;
    logic               last_px;
    logic [LW-1:0]      pra;
    logic [LW-1:0]      prb;
    logic               roots;
    logic               merge_wr;
    logic [LW-1:0]      fi;
    logic [LW-1:0]      fr;
    logic               flat_act;
    logic               cnt_hit;

    function automatic logic [AREA_W-1:0] sat_add(input logic [AREA_W-1:0] a,
                                                  input logic [AREA_W-1:0] b);
        logic [AREA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[AREA_W] ? '1 : s[AREA_W-1:0];
    endfunction

    always_comb begin
        take    = i_valid && o_ready && (state == S_LABEL || (state == S_IDLE && i_sof));
        // An i_sof pixel is always (0,0) of a fresh frame, whatever the counters say.
        eff_row = i_sof ? '0 : row;
        eff_col = i_sof ? '0 : col;
        eff_nl  = i_sof ? NLW'(1) : next_label;
        has_n   = (eff_row != '0);
        has_w   = (eff_col != '0);
        has_e   = (eff_col != COL_LAST);
        ne_col  = has_e ? eff_col + 1'b1 : eff_col;
        n_raw   = lb[eff_col];

        nb[0] = has_w ? w_lab : '0;
        nb[1] = has_n ? n_raw : '0;
        nb[2] = (CONNECT == 8 && has_n && has_w) ? nw_lab : '0;
        nb[3] = (CONNECT == 8 && has_n && has_e) ? lb[ne_col] : '0;

        lo     = '0;
        hi     = '0;
        any_nb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (nb[k] != '0) begin
                if (!any_nb || nb[k] < lo) lo = nb[k];
                if (!any_nb || nb[k] > hi) hi = nb[k];
                any_nb = 1'b1;
            end
        end

        // When W and NE disagree they are the pair to merge; N/NW already share a
        // label with one of them, so the pair (W,NE) covers every equivalence.
        if (nb[0] != '0 && nb[3] != '0 && nb[0] != nb[3]) begin
            pa = (nb[0] < nb[3]) ? nb[0] : nb[3];
            pb = (nb[0] < nb[3]) ? nb[3] : nb[0];
        end else begin
            pa = lo;
            pb = hi;
        end

        lab        = '0;
        alloc      = 1'b0;
        inc        = 1'b0;
        ovf_px     = 1'b0;
        need_merge = 1'b0;
        if (i_pixel) begin
            if (!any_nb) begin
                if (eff_nl == NL_FULL) begin
                    ovf_px = 1'b1;
                end else begin
                    lab   = eff_nl[LW-1:0];
                    alloc = 1'b1;
                end
            end else begin
                lab        = pa;
                inc        = 1'b1;
                need_merge = (pa != pb);
            end
        end
        last_px = (eff_row == ROW_LAST) && (eff_col == COL_LAST);

        pra      = par[ra];
        prb      = par[rb];
        roots    = (pra == ra) && (prb == rb);
        merge_wr = (state == S_MERGE) && roots && (ra != rb);

        // Ascending order means par[i] < i is already flattened, so two hops reach the root.
        fi       = idx[LW-1:0];
        fr       = par[par[fi]];
        flat_act = (state == S_FLATTEN) && (idx < next_label);
        cnt_hit  = (par[fi] == fi) && (area[fi] >= min_area_q);
    end

    always_ff @(posedge i_clk) begin
        if (take) begin
            lb[eff_col] <= lab;
        end
        if (take && alloc) begin
            par[lab]  <= lab;
            area[lab] <= AREA_W'(1);
        end
        if (take && inc) begin
            area[pa] <= sat_add(area[pa], AREA_W'(1));
        end
        if (merge_wr) begin
            if (ra < rb) par[rb] <= ra;
            else         par[ra] <= rb;
        end
        if (flat_act) begin
            par[fi] <= fr;
            if (fr != fi) begin
                area[fr] <= sat_add(area[fr], area[fi]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            o_ready    <= 1'b1;
            o_done     <= 1'b0;
            o_count    <= '0;
            o_overflow <= 1'b0;
            next_label <= NLW'(1);
            row        <= '0;
            col        <= '0;
            w_lab      <= '0;
            nw_lab     <= '0;
            ra         <= '0;
            rb         <= '0;
            merge_last <= 1'b0;
            frame_ovf  <= 1'b0;
            idx        <= NLW'(1);
            cnt        <= '0;
            min_area_q <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE, S_LABEL: begin
                    if (take) begin
                        if (i_sof) begin
                            min_area_q <= i_min_area;
                            cnt        <= '0;
                        end
                        next_label <= alloc ? eff_nl + 1'b1 : eff_nl;
                        frame_ovf  <= (frame_ovf & ~i_sof) | ovf_px;
                        w_lab      <= lab;
                        nw_lab     <= n_raw;
                        if (eff_col == COL_LAST) begin
                            col <= '0;
                            row <= eff_row + 1'b1;
                        end else begin
                            col <= eff_col + 1'b1;
                            row <= eff_row;
                        end
                        if (need_merge) begin
                            ra         <= pa;
                            rb         <= pb;
                            merge_last <= last_px;
                            state      <= S_MERGE;
                            o_ready    <= 1'b0;
                        end else if (last_px) begin
                            idx     <= NLW'(1);
                            state   <= S_FLATTEN;
                            o_ready <= 1'b0;
                        end else begin
                            state <= S_LABEL;
                        end
                    end
                end
                S_MERGE: begin
                    if (!roots) begin
                        if (pra != ra) ra <= pra;
                        if (prb != rb) rb <= prb;
                    end else if (merge_last) begin
                        idx   <= NLW'(1);
                        state <= S_FLATTEN;
                    end else begin
                        state   <= S_LABEL;
                        o_ready <= 1'b1;
                    end
                end
                S_FLATTEN: begin
                    if (idx < next_label) begin
                        idx <= idx + 1'b1;
                    end else begin
                        idx   <= NLW'(1);
                        cnt   <= '0;
                        state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (idx < next_label) begin
                        idx <= idx + 1'b1;
                        if (cnt_hit && cnt != '1) cnt <= cnt + 1'b1;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_count    <= cnt;
                    o_overflow <= frame_ovf;
                    o_done     <= 1'b1;
                    o_ready    <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blob_counter_cc.sv
// tb/tb_blob_counter_cc.sv - self-checking bench for blob_counter_cc (8-conn and 4-conn)

module tb_blob_counter_cc;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NL = 16;
    localparam int AW = 19;
    localparam int CW = 8;
    localparam int NP = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          valid [2];
    logic          sof   [2];
    logic          pix   [2];
    logic [AW-1:0] ma    [2];
    logic          ready [2];
    logic          done  [2];
    logic [CW-1:0] cnt_o [2];
    logic          ovf_o [2];

    int checks = 0;
    int errors = 0;
    int exp_cnt [2];
    int exp_ovf [2];
    int held    [2];
    int pending [2];
    int dones   [2];
    int stalls  [2];

    blob_counter_cc #(.IMG_W(W), .IMG_H(H), .NUM_LABELS(NL), .AREA_W(AW), .CNT_W(CW),
                      .CONNECT(8)) u_c8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[0]), .i_sof(sof[0]),
        .i_pixel(pix[0]), .i_min_area(ma[0]), .o_ready(ready[0]), .o_done(done[0]),
        .o_count(cnt_o[0]), .o_overflow(ovf_o[0]));

    blob_counter_cc #(.IMG_W(W), .IMG_H(H), .NUM_LABELS(NL), .AREA_W(AW), .CNT_W(CW),
                      .CONNECT(4)) u_c4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[1]), .i_sof(sof[1]),
        .i_pixel(pix[1]), .i_min_area(ma[1]), .o_ready(ready[1]), .o_done(done[1]),
        .o_count(cnt_o[1]), .o_overflow(ovf_o[1]));

    function automatic bit fg_at(input logic [NP-1:0] f, input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
        return f[r*W + c];
    endfunction

    // Reference: components by iterative min-id propagation, areas by counting pixels;
    // nnew = foreground pixels with no foreground causal neighbour (labels allocated).
    function automatic void model(input logic [NP-1:0] f, input int conn, input int mina,
                                  output int cnt, output int nnew, output int lastnb);
        int id [NP];
        int ar [NP+1];
        bit changed;
        int nb;
        for (int i = 0; i < NP; i++) id[i] = f[i] ? i + 1 : 0;
        changed = 1'b1;
        while (changed) begin
            changed = 1'b0;
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    if (f[r*W + c]) begin
                        for (int dr = -1; dr <= 1; dr++) begin
                            for (int dc = -1; dc <= 1; dc++) begin
                                if ((dr != 0 || dc != 0) && (conn == 8 || dr == 0 || dc == 0)
                                    && fg_at(f, r + dr, c + dc)
                                    && id[(r+dr)*W + c + dc] < id[r*W + c]) begin
                                    id[r*W + c] = id[(r+dr)*W + c + dc];
                                    changed = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
        for (int v = 0; v <= NP; v++) ar[v] = 0;
        for (int i = 0; i < NP; i++) if (f[i]) ar[id[i]]++;
        cnt = 0;
        for (int v = 1; v <= NP; v++) if (ar[v] > 0 && ar[v] >= mina) cnt++;
        nnew = 0;
        lastnb = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (f[r*W + c]) begin
                    nb = int'(fg_at(f, r, c - 1)) + int'(fg_at(f, r - 1, c));
                    if (conn == 8) nb += int'(fg_at(f, r - 1, c - 1)) + int'(fg_at(f, r - 1, c + 1));
                    if (nb == 0) nnew++;
                    if (r*W + c == NP - 1) lastnb = nb;
                end
            end
        end
    endfunction

    // Single compare process: every cycle o_count must hold the last expected result,
    // and each o_done must be expected and carry the expected count/overflow.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (done[k]) begin
                    dones[k]++;
                    checks++;
                    if (pending[k] == 0) begin
                        errors++;
                        $display("FAIL unexpected_done dut%0d got done=1 want 0", k);
                    end
                    checks++;
                    if (int'(cnt_o[k]) != exp_cnt[k]) begin
                        errors++;
                        $display("FAIL count dut%0d got %0d want %0d", k, cnt_o[k], exp_cnt[k]);
                    end
                    checks++;
                    if (int'(ovf_o[k]) != exp_ovf[k]) begin
                        errors++;
                        $display("FAIL overflow dut%0d got %0d want %0d", k, ovf_o[k], exp_ovf[k]);
                    end
                    held[k] = exp_cnt[k];
                    pending[k] = 0;
                end else begin
                    checks++;
                    if (int'(cnt_o[k]) != held[k]) begin
                        errors++;
                        $display("FAIL hold dut%0d got %0d want %0d", k, cnt_o[k], held[k]);
                    end
                end
            end
        end
    end

    task automatic send_px(input int k, input logic s, input logic p, output logic ok);
        int t;
        logic r;
        t = 0;
        ok = 1'b0;
        valid[k] = 1'b1;
        sof[k] = s;
        pix[k] = p;
        while (t < 1000 && !ok) begin
            @(negedge clk);
            r = ready[k];
            if (!r) stalls[k]++;
            @(posedge clk);
            t++;
            if (r) ok = 1'b1;
        end
        #1;
        valid[k] = 1'b0;
        sof[k] = 1'b0;
    endtask

    task automatic run_frame(input int k, input logic [NP-1:0] f, input int mina,
                             input int lit_cnt, input int lit_ovf, input int want_stall,
                             input string name);
        int mc, nn, lnb, lat, d0, nused;
        logic ok, allok;
        model(f, (k == 0) ? 8 : 4, mina, mc, nn, lnb);
        if (nn < NL) begin
            checks++;
            if (mc != lit_cnt) begin
                errors++;
                $display("FAIL model_%s dut%0d got %0d want %0d", name, k, mc, lit_cnt);
            end
        end
        exp_cnt[k] = (nn >= NL) ? lit_cnt : mc;
        exp_ovf[k] = (nn >= NL) ? 1 : 0;
        checks++;
        if (exp_ovf[k] != lit_ovf) begin
            errors++;
            $display("FAIL model_ovf_%s dut%0d got %0d want %0d", name, k, exp_ovf[k], lit_ovf);
        end
        nused = (nn >= NL) ? NL - 1 : nn;
        pending[k] = 1;
        d0 = dones[k];
        stalls[k] = 0;
        ma[k] = AW'(mina);
        allok = 1'b1;
        for (int i = 0; i < NP; i++) begin
            send_px(k, i == 0, f[i], ok);
            allok &= ok;
        end
        checks++;
        if (!allok) begin
            errors++;
            $display("FAIL accept_%s dut%0d got timeout want all pixels accepted", name, k);
        end
        if (want_stall >= 0) begin
            checks++;
            if ((stalls[k] > 0) != (want_stall > 0)) begin
                errors++;
                $display("FAIL stall_%s dut%0d got %0d stall cycles want_stall %0d",
                         name, k, stalls[k], want_stall);
            end
        end
        lat = 0;
        while (lat < 1000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done[k]) break;
        end
        checks++;
        if (lat >= 1000) begin
            errors++;
            $display("FAIL done_timeout_%s dut%0d got no done want done", name, k);
        end else if (lnb < 2) begin
            checks++;
            if (lat != 2 * nused + 3) begin
                errors++;
                $display("FAIL latency_%s dut%0d got %0d want %0d", name, k, lat, 2 * nused + 3);
            end
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (dones[k] != d0 + 1) begin
            errors++;
            $display("FAIL done_count_%s dut%0d got %0d want %0d", name, k, dones[k] - d0, 1);
        end
    endtask

    logic [NP-1:0] f_zero, f_sq2, f_u, f_diag, f_chk, f_one;

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

    initial begin
        logic ok;
        int d0;
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0; sof[k] = 1'b0; pix[k] = 1'b0; ma[k] = AW'(1);
            exp_cnt[k] = 0; exp_ovf[k] = 0; held[k] = 0; pending[k] = 0;
            dones[k] = 0; stalls[k] = 0;
        end
        f_zero = '0;
        f_sq2  = '0;
        f_u    = '0;
        f_diag = '0;
        f_chk  = '0;
        f_one  = '0;
        f_sq2[1*W+1] = 1'b1; f_sq2[1*W+2] = 1'b1; f_sq2[2*W+1] = 1'b1; f_sq2[2*W+2] = 1'b1;
        f_sq2[3*W+5] = 1'b1; f_sq2[3*W+6] = 1'b1; f_sq2[4*W+5] = 1'b1; f_sq2[4*W+6] = 1'b1;
        f_sq2[0*W+7] = 1'b1;
        for (int r = 0; r < H; r++) begin
            f_u[r*W+1] = 1'b1;
            f_u[r*W+5] = 1'b1;
        end
        for (int c = 1; c <= 5; c++) f_u[5*W+c] = 1'b1;
        f_diag[0] = 1'b1; f_diag[1*W+1] = 1'b1; f_diag[2*W+2] = 1'b1;
        for (int i = 0; i < NP; i++) f_chk[i] = ((i / W + i % W) % 2) == 0;
        f_one[2*W+3] = 1'b1; f_one[2*W+4] = 1'b1; f_one[3*W+3] = 1'b1; f_one[3*W+4] = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ready[k] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got %0d want 1", k, ready[k]); end
            checks++;
            if (done[k] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d got %0d want 0", k, done[k]); end
            checks++;
            if (cnt_o[k] !== 8'd0) begin errors++; $display("FAIL reset_count dut%0d got %0d want 0", k, cnt_o[k]); end
            checks++;
            if (ovf_o[k] !== 1'b0) begin errors++; $display("FAIL reset_ovf dut%0d got %0d want 0", k, ovf_o[k]); end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 2; k++) begin
            run_frame(k, f_zero, 1, 0, 0, 0, "zero");
            run_frame(k, f_sq2, 1, 3, 0, -1, "squares");
            run_frame(k, f_sq2, 4, 2, 0, -1, "squares_min4");
            run_frame(k, f_u, 1, 1, 0, 1, "ushape");
            run_frame(k, f_diag, 1, (k == 0) ? 1 : 3, 0, -1, "diag");
            run_frame(k, f_chk, 1, (k == 0) ? 1 : 15, (k == 0) ? 0 : 1, -1, "checker");
            for (int i = 0; i < 20; i++) send_px(k, i == 0, f_chk[i], ok);
            run_frame(k, f_one, 1, 1, 0, -1, "abort_restart");
        end

        // Reset while the frame is being flattened: result lost, no o_done.
        d0 = dones[0];
        pending[0] = 0;
        ma[0] = AW'(1);
        for (int i = 0; i < NP; i++) send_px(0, i == 0, f_sq2[i], ok);
        @(posedge clk);
        @(posedge clk);
        #1;
        held[0] = 0;
        held[1] = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cnt_o[0] !== 8'd0) begin errors++; $display("FAIL rst_flatten_count got %0d want 0", cnt_o[0]); end
        checks++;
        if (ready[0] !== 1'b1) begin errors++; $display("FAIL rst_flatten_ready got %0d want 1", ready[0]); end
        checks++;
        if (dones[0] != d0) begin errors++; $display("FAIL rst_flatten_done got %0d dones want 0", dones[0] - d0); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
